led_pulse_stretcher: RTL
========================

# led_pulse_stretcher

Output-side counterpart of the pushbutton debouncer. It takes single-cycle event pulses from the core and turns each one into a human-visible LED blink: a fixed ON time followed by a fixed OFF gap. Pulses that arrive while a blink is in progress are queued, so every event is displayed. It sits between core status strobes and the BASYS3 LED pins.

## Interface
- `ON_CYCLES`, default 4000000: LED-on time in clock cycles (40 ms at 100 MHz); must be ≥1.
- `OFF_CYCLES`, default 4000000: minimum LED-off gap after each blink, in cycles; must be ≥1.
- `PEND_W`, default 4: width of the pending-event counter; it saturates at 2^PEND_W−1.
- `CLK` input 1: 100 MHz system clock, rising edge.
- `clear_n` input 1: asynchronous, active-low reset.
- `pulse_in` input 1: event strobe; each high cycle is one event.
- `led_out` output 1: LED drive, registered.
- `busy` output 1: high while in ON or OFF.
- `pending` output PEND_W: number of queued events not yet displayed.
- `overflow` output 1: sticky flag; set when an event is lost to saturation.

## Operation
- Reset: state IDLE, `led_out`=0, `busy`=0, `pending`=0, `overflow`=0, counter=0.
- Down-counter width: $clog2(max(ON_CYCLES, OFF_CYCLES)), minimum 1.
- Request: `req = pulse_in | (pending != 0)`.
- IDLE: if `req`, go to ON and load counter with ON_CYCLES−1. Otherwise stay.
- ON: `led_out`=1. Counter decrements each cycle. At counter==0, go to OFF and load OFF_CYCLES−1.
- OFF: `led_out`=0. Counter decrements each cycle. At counter==0:
  - if `req`, go to ON and load ON_CYCLES−1;
  - otherwise go to IDLE.
- Consumption happens on every transition into ON:
  - if `pulse_in` is high, that pulse is consumed and `pending` is unchanged;
  - otherwise `pending` decrements by 1.
- A `pulse_in` that is not consumed in its cycle increments `pending`, saturating at 2^PEND_W−1.
  - If `pending` is already at max, the pulse is dropped, `pending` holds, and `overflow` is set.
- `overflow` clears only on reset.
- `busy` = (state != IDLE).
- Unused state encodings go to IDLE on the next clock.

## Timing
- `pulse_in` high at cycle t while IDLE:
  - `led_out` is high for cycles t+1 … t+ON_CYCLES;
  - `led_out` is low for cycles t+ON_CYCLES+1 … t+ON_CYCLES+OFF_CYCLES;
  - state is IDLE at t+ON_CYCLES+OFF_CYCLES+1 if nothing is queued.
- Back-to-back blinks repeat with period ON_CYCLES+OFF_CYCLES and no IDLE cycle between them.
- `pending` and `overflow` update on the same clock edge as the triggering `pulse_in`, so they are visible at t+1.
- Reset mid-blink: all outputs drop immediately (asynchronously) and the queue is discarded.
- `pulse_in` is assumed synchronous to `CLK`; no synchronizer is included.

## Configuration
- `LED_STRETCH_QUEUE_EN` defined: queuing behaves as described above.
- `LED_STRETCH_QUEUE_EN` undefined:
  - pulses arriving while `busy` (and not consumed at the OFF→ON decision point) are dropped without setting `overflow`;
  - `pending` is tied to 0 and `overflow` is tied to 0;
  - `req = pulse_in` only.

## Test plan
Parameters for all scenarios: ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2, macro defined unless stated.
- **Single pulse:** pulse at t0 → `led_out` 1 at t1–t4 and 0 at t5–t7; `busy` 1 at t1–t7 and 0 at t8; `pending` stays 0.
- **Queued pulses:** pulse at t0, then pulses at t2, t3, t4 → `pending` reads 1, 2, 3 at t3, t4, t5. Four blinks start at t1, t8, t15, t22; `pending` reaches 0 after the t22 entry; IDLE at t29.
- **Saturation:** pulse at t0, then pulses at t1–t4 → `pending`=3 and `overflow`=1 from t5. Exactly 4 blinks occur; `overflow` stays 1 afterwards.
- **Pulse on final OFF cycle:** pulse at t0, then pulse at t7 → second ON at t8–t11; `pending` is never nonzero.
- **Reset mid-ON:** `pending`=2, then `clear_n` low at t2 → `led_out`, `busy`, and `pending` are 0 before the next edge; after release the block is IDLE and there are no further blinks.
- **Macro undefined:** pulse at t0, then pulse at t2 → one blink only; `pending`=0 and `overflow`=0 throughout.

Source files
------------

// File: rtl/led_pulse_stretcher.sv
// LED pulse stretcher: turns single-cycle event strobes into visible ON/OFF blinks.
// Optional event queue (pending counter + sticky overflow) enabled by LED_STRETCH_QUEUE_EN.
module led_pulse_stretcher #(
  parameter int ON_CYCLES  = 4000000,
  parameter int OFF_CYCLES = 4000000,
  parameter int PEND_W     = 4
) (
  input  logic              CLK,
  input  logic              clear_n,
  input  logic              pulse_in,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_C = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          led_q, led_d;
  logic          req;
  logic          enter_on;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    enter_on = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d  = S_ON;
          cnt_d    = ON_LOAD;
          enter_on = 1'b1;
        end
      end
      S_ON: begin
        if (cnt_q == '0) begin
          state_d = S_OFF;
          cnt_d   = OFF_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_OFF: begin
        if (cnt_q == '0) begin
          if (req) begin
            state_d  = S_ON;
            cnt_d    = ON_LOAD;
            enter_on = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    led_d = (state_d == S_ON);
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample
  // the pre-edge values together, independent of statement order.
  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

  assign led_out = led_q;
  assign busy    = (state_q != S_IDLE);

`ifdef LED_STRETCH_QUEUE_EN
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;

  assign req = pulse_in | (pend_q != '0);

  // A pulse seen on an ON entry is displayed directly; otherwise the queue feeds it.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (enter_on && !pulse_in) begin
      pend_d = pend_q - PEND_ONE;
    end else if (pulse_in && !enter_on) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pending  = pend_q;
  assign overflow = ovf_q;
`else
  assign req      = pulse_in;
  assign pending  = '0;
  assign overflow = 1'b0;
`endif

endmodule
